// File: rtl/tb_reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer_if
//
// Groups the sequencer's control inputs and reset/status outputs into one
// bundle. Clock and reset stay plain ports on the sequencer.
//
//   start               : level, begins the cold power-up sequence from IDLE
//   warm_rst_req        : level, re-enters the functional reset from DONE
//   dut_ready           : DUT out-of-reset indication
//   lan_powergood_rst_b : power-good reset, active-low
//   tb_rst_b            : functional reset, active-low
//   seq_done            : high while the sequence is complete
//   wd_expired          : sticky watchdog expiry flag
//   state               : current sequencer state encoding (debug)
//
// master : the side that drives the requests (bench top)
// slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface tb_reset_sequencer_if;
  logic       start;
  logic       warm_rst_req;
  logic       dut_ready;
  logic       lan_powergood_rst_b;
  logic       tb_rst_b;
  logic       seq_done;
  logic       wd_expired;
  logic [2:0] state;

  modport master (
    output start, warm_rst_req, dut_ready,
    input  lan_powergood_rst_b, tb_rst_b, seq_done, wd_expired, state
  );

  modport slave (
    input  start, warm_rst_req, dut_ready,
    output lan_powergood_rst_b, tb_rst_b, seq_done, wd_expired, state
  );
endinterface

// File: rtl/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Cycle-accurate power-good / functional-reset sequencer. Counts tb_clk cycles
// in microsecond units, releases lan_powergood_rst_b, then tb_rst_b, then waits
// for dut_ready under a watchdog. A warm reset request in DONE re-runs only the
// functional-reset phase.
//
// Ports:
//   tb_clk : sole clock, all logic on posedge
//   tb_rst : asynchronous, active-high reset
//   bus    : tb_reset_sequencer_if.slave (requests in, resets/status out)
// -----------------------------------------------------------------------------
module tb_reset_sequencer #(
  parameter int CYC_PER_US   = 100,
  parameter int PWRGD_DLY_US = 10,
  parameter int RST_DLY_US   = 5,
  parameter int WD_US        = 1000,
  parameter int CNT_W        = 32
) (
  input  logic                 tb_clk,
  input  logic                 tb_rst,
  tb_reset_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PWRGD_WAIT = 3'd1,
    S_RST_WAIT   = 3'd2,
    S_READY_WAIT = 3'd3,
    S_DONE       = 3'd4,
    S_ERROR      = 3'd5
  } state_e;

  localparam int MAX_US =
    (PWRGD_DLY_US > RST_DLY_US) ?
      ((PWRGD_DLY_US > WD_US) ? PWRGD_DLY_US : WD_US) :
      ((RST_DLY_US   > WD_US) ? RST_DLY_US   : WD_US);

  localparam longint PG_CYC  = longint'(PWRGD_DLY_US) * longint'(CYC_PER_US);
  localparam longint RS_CYC  = longint'(RST_DLY_US)   * longint'(CYC_PER_US);
  localparam longint WD_CYC  = longint'(WD_US)        * longint'(CYC_PER_US);
  localparam longint MAX_CYC = longint'(MAX_US)       * longint'(CYC_PER_US);

  // Configuration guard: every delay must be non-zero and the longest delay
  // (in cycles) must fit in the counter, since the counter never wraps.
  if (PWRGD_DLY_US < 1 || RST_DLY_US < 1 || WD_US < 1 || CYC_PER_US < 1) begin : g_bad_delay
    $fatal(1, "tb_reset_sequencer: all delays and CYC_PER_US must be >= 1");
  end
  if (CNT_W < 63 && MAX_CYC > ((longint'(1) << CNT_W) - 1)) begin : g_bad_width
    $fatal(1, "tb_reset_sequencer: CNT_W too narrow for the longest delay");
  end

  // Terminal counts: the counter starts at 0, so N cycles end at N-1.
  localparam logic [CNT_W-1:0] PG_TC = CNT_W'(PG_CYC - 1);
  localparam logic [CNT_W-1:0] RS_TC = CNT_W'(RS_CYC - 1);
  localparam logic [CNT_W-1:0] WD_TC = CNT_W'(WD_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pg_q, pg_d;
  logic             rb_q, rb_d;
  logic             done_q, done_d;
  logic             wd_q, wd_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pg_q    <= 1'b0;
      rb_q    <= 1'b0;
      done_q  <= 1'b0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pg_q    <= pg_d;
      rb_q    <= rb_d;
      done_q  <= done_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold default first; any path
    // that leaves one unassigned would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pg_d    = pg_q;
    rb_d    = rb_q;
    done_d  = done_q;
    wd_d    = wd_q;

    case (state_q)
      S_IDLE: begin
        pg_d = 1'b0;
        rb_d = 1'b0;
        if (bus.start) begin
          state_d = S_PWRGD_WAIT;
          cnt_d   = '0;
        end
      end

      S_PWRGD_WAIT: begin
        if (cnt_q == PG_TC) begin
          state_d = S_RST_WAIT;
          pg_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RST_WAIT: begin
        if (cnt_q == RS_TC) begin
          state_d = S_READY_WAIT;
          rb_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_READY_WAIT: begin
        // dut_ready takes priority over a coinciding watchdog terminal count.
        if (bus.dut_ready) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == WD_TC) begin
          state_d = S_ERROR;
          wd_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        // Warm reset re-runs only the functional-reset phase; power-good holds.
        if (bus.warm_rst_req) begin
          state_d = S_RST_WAIT;
          rb_d    = 1'b0;
          done_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      S_ERROR: begin
        // Terminal until tb_rst: everything holds.
      end

      default: begin
        // Unreachable encodings recover to a clean IDLE.
        state_d = S_IDLE;
        cnt_d   = '0;
        pg_d    = 1'b0;
        rb_d    = 1'b0;
        done_d  = 1'b0;
        wd_d    = 1'b0;
      end
    endcase
  end

  assign bus.lan_powergood_rst_b = pg_q;
  assign bus.tb_rst_b            = rb_q;
  assign bus.seq_done            = done_q;
  assign bus.wd_expired          = wd_q;
  assign bus.state               = state_q;

endmodule

// File: tb/tb_tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tb_reset_sequencer
//
// Bench for tb_reset_sequencer (WD_US overridden to 2, other parameters at
// their defaults). A timestamp-based model predicts every output after each
// clock edge; directed scenarios pin the model with literal timings, then a
// randomized phase exercises arbitrary interleavings.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tb_reset_sequencer;

  localparam int CYC_PER_US = 100;
  localparam int PG = 10 * CYC_PER_US;   // start -> power-good release
  localparam int RS = 5  * CYC_PER_US;   // power-good/warm -> tb_rst_b release
  localparam int WD = 2  * CYC_PER_US;   // tb_rst_b release -> watchdog

  logic tb_clk = 1'b0;
  logic tb_rst = 1'b1;

  tb_reset_sequencer_if bus ();

  tb_reset_sequencer #(
    .CYC_PER_US  (CYC_PER_US),
    .PWRGD_DLY_US(10),
    .RST_DLY_US  (5),
    .WD_US       (2),
    .CNT_W       (32)
  ) u_dut (
    .tb_clk(tb_clk),
    .tb_rst(tb_rst),
    .bus   (bus.slave)
  );

  always #5 tb_clk = ~tb_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the sequence is described by when things happen.
  //   running : a cold start has been accepted since the last reset
  //   t_pg    : edge after which power-good is released
  //   t_rr    : edge after which tb_rst_b is released (moved by warm reset)
  //   m_done / m_err : sequence completed / watchdog fired
  // ---------------------------------------------------------------------------
  int cyc = 0;
  bit running = 0, m_done = 0, m_err = 0;
  int t_pg = 0, t_rr = 0;

  always @(posedge tb_rst) begin
    running = 0; m_done = 0; m_err = 0;
  end

  always @(posedge tb_clk) begin
    cyc = cyc + 1;
    if (!tb_rst) begin
      if (!running) begin
        if (bus.start) begin
          running = 1;
          t_pg = cyc + PG;
          t_rr = cyc + PG + RS;
        end
      end else if (m_err) begin
        // terminal
      end else if (m_done) begin
        if (bus.warm_rst_req) begin
          m_done = 0;
          t_rr = cyc + RS;
        end
      end else if (cyc > t_rr) begin
        if (bus.dut_ready)           m_done = 1;
        else if (cyc - t_rr == WD)   m_err  = 1;
      end
    end
  end

  function automatic logic [6:0] model_out();
    logic       pg, rb;
    logic [2:0] st;
    pg = running && (cyc >= t_pg);
    rb = running && (cyc >= t_rr);
    if (!running)        st = 3'd0;
    else if (m_err)      st = 3'd5;
    else if (m_done)     st = 3'd4;
    else if (cyc < t_pg) st = 3'd1;
    else if (cyc < t_rr) st = 3'd2;
    else                 st = 3'd3;
    return {pg, rb, m_done, m_err, st};
  endfunction

  // Per-cycle comparison plus rise-time capture for the literal checks.
  int pg_rise = -1, rb_rise = -1, done_rise = -1, wd_rise = -1;
  logic prev_pg = 0, prev_rb = 0, prev_done = 0, prev_wd = 0;

  always @(negedge tb_clk) begin
    check($sformatf("cycle %0d {pg,rb,done,wd,state}", cyc),
          {bus.lan_powergood_rst_b, bus.tb_rst_b, bus.seq_done, bus.wd_expired, bus.state},
          model_out());
    if (bus.lan_powergood_rst_b === 1'b1 && prev_pg !== 1'b1) pg_rise   = cyc;
    if (bus.tb_rst_b            === 1'b1 && prev_rb !== 1'b1) rb_rise   = cyc;
    if (bus.seq_done            === 1'b1 && prev_done !== 1'b1) done_rise = cyc;
    if (bus.wd_expired          === 1'b1 && prev_wd !== 1'b1) wd_rise   = cyc;
    prev_pg   = bus.lan_powergood_rst_b;
    prev_rb   = bus.tb_rst_b;
    prev_done = bus.seq_done;
    prev_wd   = bus.wd_expired;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 ns after the falling edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge tb_clk);
    #1;
  endtask

  task automatic do_reset();
    bus.start = 0; bus.warm_rst_req = 0; bus.dut_ready = 0;
    tb_rst = 1;
    step(); step();
    tb_rst = 0;
  endtask

  task automatic pulse_start(output int t0);
    bus.start = 1;
    t0 = cyc + 1;
    step();
    bus.start = 0;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.lan_powergood_rst_b;
      1:       return bus.tb_rst_b;
      2:       return bus.seq_done;
      default: return bus.wd_expired;
    endcase
  endfunction

  task automatic wait_high(input int which, input int budget, input string name);
    int n = 0;
    while (sig(which) !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check({name, " reached within budget"}, sig(which), 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, tw;
    bus.start = 0; bus.warm_rst_req = 0; bus.dut_ready = 0;
    step(); step();
    check("reset state {pg,rb,done,wd,state}",
          {bus.lan_powergood_rst_b, bus.tb_rst_b, bus.seq_done, bus.wd_expired, bus.state}, 7'd0);
    tb_rst = 0;

    // Cold boot with dut_ready tied high.
    bus.dut_ready = 1;
    pulse_start(t0);
    wait_high(2, 2000, "cold seq_done");
    check("cold pg rise",   pg_rise,   t0 + 1000);
    check("cold rb rise",   rb_rise,   t0 + 1500);
    check("cold done rise", done_rise, t0 + 1501);
    check("cold state",     bus.state, 3'd4);

    // start held high through DONE: no re-sequence.
    bus.start = 1;
    repeat (300) step();
    check("start held state", bus.state, 3'd4);
    check("start held resets", {bus.lan_powergood_rst_b, bus.tb_rst_b}, 2'b11);
    bus.start = 0;

    // Warm reset from DONE.
    tw = cyc + 1;
    bus.warm_rst_req = 1;
    step();
    bus.warm_rst_req = 0;
    check("warm rb/done drop", {bus.tb_rst_b, bus.seq_done}, 2'b00);
    check("warm pg holds", bus.lan_powergood_rst_b, 1'b1);
    wait_high(1, 600, "warm rb");
    check("warm rb rise", rb_rise, tw + 500);
    wait_high(2, 10, "warm seq_done");
    check("warm state", bus.state, 3'd4);

    // Watchdog, with an ignored warm request during PWRGD_WAIT.
    do_reset();
    pulse_start(t0);
    repeat (300) step();
    bus.warm_rst_req = 1;
    step();
    bus.warm_rst_req = 0;
    wait_high(3, 2500, "watchdog");
    check("wd pg rise", pg_rise, t0 + 1000);
    check("wd rb rise", rb_rise, t0 + 1500);
    check("wd rise",    wd_rise, t0 + 1700);
    check("wd state",   bus.state, 3'd5);
    repeat (1000) step();
    check("wd sticky", bus.wd_expired, 1'b1);
    bus.dut_ready = 1;
    repeat (50) step();
    check("wd after ready {done,wd,state}", {bus.seq_done, bus.wd_expired, bus.state}, 5'b0_1_101);
    bus.dut_ready = 0;

    // Race: dut_ready sampled exactly on the watchdog terminal-count edge.
    do_reset();
    pulse_start(t0);
    while (cyc < t0 + 1699) step();
    bus.dut_ready = 1;
    step();
    bus.dut_ready = 0;
    check("race {done,wd,state}", {bus.seq_done, bus.wd_expired, bus.state}, 5'b1_0_100);

    // Mid-sequence asynchronous reset at T0+1200.
    do_reset();
    pulse_start(t0);
    while (cyc < t0 + 1199) step();
    @(posedge tb_clk);
    #2;
    check("mid pg before reset", bus.lan_powergood_rst_b, 1'b1);
    tb_rst = 1;
    #1;
    check("mid async reset {pg,rb,done,wd,state}",
          {bus.lan_powergood_rst_b, bus.tb_rst_b, bus.seq_done, bus.wd_expired, bus.state}, 7'd0);
    step(); step();
    tb_rst = 0;
    bus.dut_ready = 1;
    pulse_start(t0);
    wait_high(2, 2000, "replay seq_done");
    check("replay pg rise", pg_rise, t0 + 1000);
    check("replay rb rise", rb_rise, t0 + 1500);

    // Randomized interleaving of all inputs, including async resets.
    do_reset();
    for (int i = 0; i < 12000; i++) begin
      bus.start        = ($urandom_range(0, 19) == 0);
      bus.warm_rst_req = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 299) == 0) bus.dut_ready = ~bus.dut_ready;
      if ($urandom_range(0, 3999) == 0) begin
        tb_rst = 1;
        step();
        tb_rst = 0;
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
